// File: rtl/jtdd_romarb.sv
// ---------------------------------------------------------------------------
// jtdd_romarb
// Shares one SDRAM ROM read port between three CPU clients:
//   client 0 = main 6809 (banked program ROM)
//   client 1 = MCU program ROM
//   client 2 = sound CPU program ROM
// Each client sees a plain cs/addr -> data/ok ROM interface. A one-word
// (16-bit) cache per client serves both bytes of the last fetched word, so
// sequential byte fetches only go to SDRAM once per word.
//
// Ports
//   clk, rst               system clock, synchronous active-high reset
//   downloading            ROM download in progress: flush caches, no fetches
//   main_cs/addr/data/ok   main CPU byte port   (AW0-bit byte address)
//   mcu_cs/addr/data/ok    MCU byte port        (AW1-bit byte address)
//   snd_cs/addr/data/ok    sound CPU byte port  (AW2-bit byte address)
//   sdram_req/addr         word read request, held until sdram_ack
//   sdram_ack              one-cycle pulse, request accepted
//   data_rdy/sdram_dout    one-cycle pulse with the read word
// ---------------------------------------------------------------------------
module jtdd_romarb #(
    parameter int          AW0     = 18,
    parameter int          AW1     = 14,
    parameter int          AW2     = 15,
    parameter logic [21:0] OFFSET1 = 22'h10_0000,
    parameter logic [21:0] OFFSET2 = 22'h11_0000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           downloading,

    input  logic           main_cs,
    input  logic [AW0-1:0] main_addr,
    output logic [7:0]     main_data,
    output logic           main_ok,

    input  logic           mcu_cs,
    input  logic [AW1-1:0] mcu_addr,
    output logic [7:0]     mcu_data,
    output logic           mcu_ok,

    input  logic           snd_cs,
    input  logic [AW2-1:0] snd_addr,
    output logic [7:0]     snd_data,
    output logic           snd_ok,

    output logic           sdram_req,
    output logic [21:0]    sdram_addr,
    input  logic           sdram_ack,
    input  logic           data_rdy,
    input  logic [15:0]    sdram_dout
);

    // Common tag width: the widest client word address.
    localparam int AW01 = (AW0 > AW1) ? AW0 : AW1;
    localparam int AWM  = (AW01 > AW2) ? AW01 : AW2;
    localparam int TW   = AWM - 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_WAIT_RDY = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_nx_s;

    logic [2:0]           cs_s;
    logic [2:0][TW-1:0]   word_s;
    logic [2:0]           hit_s;
    logic [2:0]           miss_s;

    logic [2:0]           valid_r;
    logic [2:0][TW-1:0]   tag_r;
    logic [2:0][15:0]     data_r;

    logic [1:0]           gnt_r;
    logic [1:0]           last_grant_r;
    logic [TW-1:0]        ftag_r;

    logic [2:0]           pick_s;
    logic                 pick_valid_s;
    logic [1:0]           pick_idx_s;
    logic [TW-1:0]        pick_word_s;

    logic                 start_s;
    logic                 fill_s;

    // Round-robin pick: scan clients starting after 'last' in order 0,1,2.
    // Returns {found, index}.
    function automatic logic [2:0] rr_pick(input logic [1:0] last, input logic [2:0] req);
        logic [1:0] c;
        logic [2:0] res;
        res = 3'b000;
        c   = last;
        for (int k = 0; k < 3; k++) begin
            c = (c == 2'd2) ? 2'd0 : (c + 2'd1);
            if (req[c] && !res[2]) begin
                res = {1'b1, c};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Map a client word address into the shared SDRAM word space (mod 2^22).
    function automatic logic [21:0] sdram_word(input logic [1:0] client, input logic [TW-1:0] word);
        logic [21:0] ext;
        logic [21:0] res;
        ext = 22'(word);
        case (client)
            2'd0:    res = ext;
            2'd1:    res = ext + OFFSET1;
            default: res = ext + OFFSET2;
        endcase
        return res;
    endfunction

    // Collect the client ports into indexable vectors of word addresses.
    always_comb begin
        cs_s      = {snd_cs, mcu_cs, main_cs};
        word_s    = '0;
        word_s[0] = TW'(main_addr[AW0-1:1]);
        word_s[1] = TW'(mcu_addr[AW1-1:1]);
        word_s[2] = TW'(snd_addr[AW2-1:1]);
    end

    // Cache lookup: a hit needs a valid line whose tag matches the current word.
    always_comb begin
        hit_s  = 3'b000;
        miss_s = 3'b000;
        for (int n = 0; n < 3; n++) begin
            hit_s[n]  = cs_s[n] & valid_r[n] & (tag_r[n] == word_s[n]);
            miss_s[n] = cs_s[n] & ~hit_s[n];
        end
    end

    // Arbitration among missing clients and the word address of the winner.
    always_comb begin
        pick_s       = rr_pick(last_grant_r, miss_s);
        pick_valid_s = pick_s[2];
        pick_idx_s   = pick_s[1:0];
        pick_word_s  = word_s[0];
        case (pick_idx_s)
            2'd0:    pick_word_s = word_s[0];
            2'd1:    pick_word_s = word_s[1];
            default: pick_word_s = word_s[2];
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic. A download aborts a pending request but a
    // request already accepted must still see its data_rdy before idling.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s && !downloading) begin
                    state_nx_s = ST_WAIT_ACK;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WAIT_ACK: begin
                if (downloading) begin
                    state_nx_s = ST_IDLE;
                end else if (sdram_ack) begin
                    // ack and rdy together: the word is already here
                    state_nx_s = data_rdy ? ST_IDLE : ST_WAIT_RDY;
                end else begin
                    state_nx_s = ST_WAIT_ACK;
                end
            end
            ST_WAIT_RDY: begin
                if (data_rdy) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_WAIT_RDY;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: start of a fetch and the cache fill strobe.
    always_comb begin
        start_s = 1'b0;
        fill_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                start_s = pick_valid_s & ~downloading;
            end
            ST_WAIT_ACK: begin
                fill_s = ~downloading & sdram_ack & data_rdy;
            end
            ST_WAIT_RDY: begin
                fill_s = ~downloading & data_rdy;
            end
            default: begin
                start_s = 1'b0;
                fill_s  = 1'b0;
            end
        endcase
    end

    // SDRAM request, grant bookkeeping and cache line updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            sdram_req    <= 1'b0;
            sdram_addr   <= 22'd0;
            gnt_r        <= 2'd0;
            last_grant_r <= 2'd2;
            ftag_r       <= '0;
            valid_r      <= 3'b000;
            tag_r        <= '0;
            data_r       <= '0;
        end else begin
            sdram_req <= (state_nx_s == ST_WAIT_ACK);
            if (start_s) begin
                gnt_r      <= pick_idx_s;
                ftag_r     <= pick_word_s;
                sdram_addr <= sdram_word(pick_idx_s, pick_word_s);
            end else begin
                gnt_r      <= gnt_r;
                ftag_r     <= ftag_r;
                sdram_addr <= sdram_addr;
            end
            // The fill stores the fetched tag, not the current address, so a
            // client that moved during the fetch simply misses again.
            for (int n = 0; n < 3; n++) begin
                if (downloading) begin
                    valid_r[n] <= 1'b0;
                end else if (fill_s && (gnt_r == 2'(n))) begin
                    valid_r[n] <= 1'b1;
                    tag_r[n]   <= ftag_r;
                    data_r[n]  <= sdram_dout;
                end else begin
                    valid_r[n] <= valid_r[n];
                end
            end
            if (fill_s) begin
                last_grant_r <= gnt_r;
            end else begin
                last_grant_r <= last_grant_r;
            end
        end
    end

    // Client byte outputs: ok follows the hit in the same cycle.
    always_comb begin
        main_ok = hit_s[0];
        mcu_ok  = hit_s[1];
        snd_ok  = hit_s[2];
        if (main_addr[0]) begin
            main_data = data_r[0][15:8];
        end else begin
            main_data = data_r[0][7:0];
        end
        if (mcu_addr[0]) begin
            mcu_data = data_r[1][15:8];
        end else begin
            mcu_data = data_r[1][7:0];
        end
        if (snd_addr[0]) begin
            snd_data = data_r[2][15:8];
        end else begin
            snd_data = data_r[2][7:0];
        end
    end

endmodule
